// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Latency: INHIBIT_CYCLES of clock inhibit, then paced by the device clock; inputs see 3 cycles of sync/edge delay.
// Backpressure: tx_ready is high only in IDLE; tx_valid outside IDLE is dropped, not queued.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_TIMEOUT  = 750000,
  parameter int FRAME_TIMEOUT  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  // One counter serves both the inhibit hold and the start timeout, so size it for the larger.
  localparam int CMAX = (START_TIMEOUT > INHIBIT_CYCLES) ? START_TIMEOUT : INHIBIT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int FW   = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE    = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shift;

  logic clk_s1, sync_clk, prev_clk;
  logic dat_s1, sync_dat;
  logic fall_edge;

  // Two-flop synchronizers on the raw lines plus a delayed copy of the clock for edge detection.
  // Reset to the idle-high level so leaving reset never looks like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      sync_clk <= 1'b1;
      prev_clk <= 1'b1;
      dat_s1   <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      sync_clk <= clk_s1;
      prev_clk <= sync_clk;
      dat_s1   <= ps2_dat_in;
      sync_dat <= dat_s1;
    end
  end

  assign fall_edge = prev_clk & ~sync_clk;
  assign tx_ready  = (state == S_IDLE);

  // Frame sequencer: all line controls and status pulses are registered here.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      frame_cnt  <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_valid) begin
            shift      <= {~^tx_data, tx_data};
            cnt        <= '0;
            ps2_clk_oe <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (cnt == INH_LAST) begin
            // Release the clock; data stays low as the start bit.
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= S_RTS;
          end else begin
            cnt <= cnt + 1'b1;
            // Pull data low one cycle before release so it is already low when the clock floats up.
            if (cnt == INH_PRE) ps2_dat_oe <= 1'b1;
          end
        end

        S_RTS: begin
          if (fall_edge) begin
            ps2_dat_oe <= ~shift[0];
            shift      <= {1'b0, shift[8:1]};
            bit_cnt    <= '0;
            frame_cnt  <= '0;
            state      <= S_SHIFT;
          end else if (cnt == START_LAST) begin
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_SHIFT: begin
          if (frame_cnt == FRAME_LAST) begin
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            state      <= S_ERROR;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (fall_edge) begin
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd8) begin
                // Tenth edge: float data for the stop bit.
                ps2_dat_oe <= 1'b0;
                state      <= S_ACK;
              end else begin
                ps2_dat_oe <= ~shift[0];
                shift      <= {1'b0, shift[8:1]};
              end
            end
          end
        end

        S_ACK: begin
          if (frame_cnt == FRAME_LAST) begin
            tx_error <= 1'b1;
            state    <= S_ERROR;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (fall_edge) begin
              if (!sync_dat) begin
                state <= S_WAIT_IDLE;
              end else begin
                tx_error <= 1'b1;
                state    <= S_ERROR;
              end
            end
          end
        end

        S_WAIT_IDLE: begin
          if (frame_cnt == FRAME_LAST) begin
            tx_error <= 1'b1;
            state    <= S_ERROR;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
            if (sync_clk && sync_dat) begin
              tx_done <= 1'b1;
              state   <= S_DONE;
            end
          end
        end

        S_DONE: begin
          tx_done <= 1'b0;
          tx_busy <= 1'b0;
          state   <= S_IDLE;
        end

        S_ERROR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_error   <= 1'b0;
          tx_busy    <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_busy    <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a cycle-paced PS/2 device model drives the open-collector lines
// and records what it samples; expected frames come from the byte's bits and a ones count.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int ST  = 200;
  localparam int FT  = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       tx_busy, tx_done, tx_error;
  logic       dev_clk_hi = 1'b1;
  logic       dev_dat_hi = 1'b1;

  int errors = 0;
  int checks = 0;

  // Wired-AND open-collector lines with pull-ups.
  assign ps2_clk_in = dev_clk_hi & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat_hi & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (ST),
    .FRAME_TIMEOUT (FT)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #10 clk = ~clk;

  // Monitor on the falling edge: running totals and timestamps of interesting events.
  int   cyc = 0, done_tot = 0, err_tot = 0, clkoe_tot = 0;
  int   rel_cyc = 0, err_cyc = 0, done_cyc = 0, acc_cyc = 0;
  logic prev_clkoe = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (tx_done) begin done_tot++; done_cyc = cyc; end
    if (tx_error) begin err_tot++; err_cyc = cyc; end
    if (ps2_clk_oe) clkoe_tot++;
    if (prev_clkoe && !ps2_clk_oe) rel_cyc = cyc;
    if (tx_ready && tx_valid && !reset) acc_cyc = cyc;
    prev_clkoe = ps2_clk_oe;
  end

  // Expected line levels as seen by the device: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] expect_bits(input logic [7:0] d);
    logic [10:0] b;
    int ones;
    ones = 0;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      b[i+1] = d[i];
      if (d[i]) ones++;
    end
    b[9]  = (ones % 2 == 0);
    b[10] = 1'b1;
    return b;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, samples the start bit, then produces nfall clock pulses
  // (40-cycle period) sampling data at each rising edge; pulls data low for ACK on pulse 11.
  task automatic device(input int nfall, input bit do_ack, output logic [10:0] bits,
                        output bit rts_seen, output int first_fall);
    bits       = '0;
    rts_seen   = 1'b0;
    first_fall = 0;
    for (int i = 0; i < 300 && !rts_seen; i++) begin
      if (!ps2_clk_oe && ps2_dat_oe) rts_seen = 1'b1;
      else step(1);
    end
    if (!rts_seen || nfall == 0) return;
    step(10);
    bits[0] = ps2_dat_in;
    for (int k = 1; k <= nfall; k++) begin
      if (k == 11 && do_ack) begin
        dev_dat_hi = 1'b0;
        step(5);
      end
      dev_clk_hi = 1'b0;
      if (k == 1) first_fall = cyc + 1;
      step(20);
      if (k <= 10) bits[k] = ps2_dat_in;
      dev_clk_hi = 1'b1;
      if (k == 11) dev_dat_hi = 1'b1;
      step(20);
    end
  endtask

  task automatic wait_end(input int base, input string name);
    for (int i = 0; i < 5000; i++) begin
      if (done_tot + err_tot > base) return;
      step(1);
    end
    errors++;
    checks++;
    $display("FAIL %s: frame never ended (done/error count stayed %0d)", name, base);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    checks++;
    if (ps2_dat_oe !== 1'b0) begin errors++; $display("FAIL reset_dat_oe got=%b exp=0", ps2_dat_oe); end
    checks++;
    if ({tx_busy, tx_done, tx_error} !== 3'b000) begin
      errors++; $display("FAIL reset_status busy/done/err got=%b exp=000", {tx_busy, tx_done, tx_error});
    end
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    checks++;
    reset = 1'b0;
    step(5);
  endtask

  task automatic test_frame(input logic [7:0] d, input string name);
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0, c0;
    d0 = done_tot; e0 = err_tot; c0 = clkoe_tot;
    send(d);
    device(11, 1'b1, bits, rts, ff);
    wait_end(d0 + e0, name);
    step(5);
    if (bits !== expect_bits(d) || !rts) begin
      errors++; $display("FAIL %s_bits got=%b exp=%b rts=%0d", name, bits, expect_bits(d), rts);
    end
    checks++;
    if (clkoe_tot - c0 !== INH) begin
      errors++; $display("FAIL %s_inhibit got=%0d cycles exp=%0d", name, clkoe_tot - c0, INH);
    end
    checks++;
    if (done_tot - d0 !== 1 || err_tot - e0 !== 0) begin
      errors++; $display("FAIL %s_pulses done=%0d err=%0d exp 1/0", name, done_tot - d0, err_tot - e0);
    end
    checks++;
    if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL %s_after busy=%b ready=%b exp 0/1", name, tx_busy, tx_ready);
    end
    checks++;
  endtask

  task automatic test_no_clock();
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0;
    d0 = done_tot; e0 = err_tot;
    send(8'($urandom));
    device(0, 1'b0, bits, rts, ff);
    wait_end(d0 + e0, "no_clock");
    step(3);
    if (err_tot - e0 !== 1 || done_tot - d0 !== 0) begin
      errors++; $display("FAIL no_clock_pulses err=%0d done=%0d exp 1/0", err_tot - e0, done_tot - d0);
    end
    checks++;
    if (err_cyc - rel_cyc !== ST) begin
      errors++; $display("FAIL no_clock_timeout got=%0d cycles exp=%0d", err_cyc - rel_cyc, ST);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
      errors++; $display("FAIL no_clock_lines clk_oe/dat_oe/ready got=%b exp=001", {ps2_clk_oe, ps2_dat_oe, tx_ready});
    end
    checks++;
  endtask

  task automatic test_no_ack();
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0;
    logic [7:0]  d;
    d0 = done_tot; e0 = err_tot;
    d = 8'($urandom);
    send(d);
    device(11, 1'b0, bits, rts, ff);
    wait_end(d0 + e0, "no_ack");
    step(3);
    if (err_tot - e0 !== 1 || done_tot - d0 !== 0) begin
      errors++; $display("FAIL no_ack_pulses err=%0d done=%0d exp 1/0", err_tot - e0, done_tot - d0);
    end
    checks++;
    if (bits !== expect_bits(d)) begin
      errors++; $display("FAIL no_ack_bits got=%b exp=%b", bits, expect_bits(d));
    end
    checks++;
  endtask

  task automatic test_stall();
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0;
    d0 = done_tot; e0 = err_tot;
    send(8'($urandom));
    device(5, 1'b1, bits, rts, ff);
    wait_end(d0 + e0, "stall");
    step(3);
    if (err_tot - e0 !== 1 || done_tot - d0 !== 0) begin
      errors++; $display("FAIL stall_pulses err=%0d done=%0d exp 1/0", err_tot - e0, done_tot - d0);
    end
    checks++;
    if (err_cyc - ff < FT || err_cyc - ff > FT + 5) begin
      errors++; $display("FAIL stall_timeout got=%0d cycles exp=%0d..%0d", err_cyc - ff, FT, FT + 5);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
      errors++; $display("FAIL stall_lines got=%b exp=00", {ps2_clk_oe, ps2_dat_oe});
    end
    checks++;
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0;
    // Bit 4 goes out on edge 5; keep it 0 so data is actively driven when reset hits.
    send(8'($urandom) & 8'hEF);
    device(5, 1'b1, bits, rts, ff);
    if ({tx_busy, ps2_dat_oe} !== 2'b11) begin
      errors++; $display("FAIL midshift_pre busy/dat_oe got=%b exp=11", {tx_busy, ps2_dat_oe});
    end
    checks++;
    d0 = done_tot; e0 = err_tot;
    reset = 1'b1;
    step(1);
    if ({ps2_clk_oe, ps2_dat_oe, tx_busy, tx_ready} !== 4'b0001) begin
      errors++; $display("FAIL midshift_reset clk_oe/dat_oe/busy/ready got=%b exp=0001",
                         {ps2_clk_oe, ps2_dat_oe, tx_busy, tx_ready});
    end
    checks++;
    reset = 1'b0;
    step(FT + 100);
    if (done_tot - d0 !== 0 || err_tot - e0 !== 0) begin
      errors++; $display("FAIL midshift_pulses done=%0d err=%0d exp 0/0", done_tot - d0, err_tot - e0);
    end
    checks++;
  endtask

  task automatic test_valid_while_busy();
    logic [10:0] bits;
    bit          rts;
    int          ff, d0, e0, c0;
    logic [7:0]  d;
    logic        ready_seen;
    d0 = done_tot; e0 = err_tot; c0 = clkoe_tot;
    d = 8'($urandom);
    send(d);
    ready_seen = 1'b0;
    tx_data  = ~d;
    tx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (tx_ready) ready_seen = 1'b1;
      step(1);
    end
    tx_valid = 1'b0;
    if (ready_seen !== 1'b0) begin errors++; $display("FAIL busy_ready got=1 exp=0"); end
    checks++;
    device(11, 1'b1, bits, rts, ff);
    wait_end(d0 + e0, "busy_valid");
    step(100);
    if (bits !== expect_bits(d)) begin
      errors++; $display("FAIL busy_bits got=%b exp=%b", bits, expect_bits(d));
    end
    checks++;
    if (clkoe_tot - c0 !== INH || done_tot - d0 !== 1) begin
      errors++; $display("FAIL busy_single_frame inhibit=%0d done=%0d exp %0d/1", clkoe_tot - c0, done_tot - d0, INH);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits_a, bits_b;
    bit          rts;
    int          ff, d0, e0;
    logic [7:0]  a, b;
    a = 8'($urandom);
    b = 8'($urandom);
    d0 = done_tot; e0 = err_tot;
    send(a);
    // Holding the next request through the first frame; it lands in the first IDLE cycle.
    tx_data  = b;
    tx_valid = 1'b1;
    device(11, 1'b1, bits_a, rts, ff);
    wait_end(d0 + e0, "b2b_first");
    tx_valid = 1'b0;
    if (acc_cyc - done_cyc !== 1) begin
      errors++; $display("FAIL b2b_accept gap got=%0d exp=1", acc_cyc - done_cyc);
    end
    checks++;
    device(11, 1'b1, bits_b, rts, ff);
    wait_end(d0 + e0 + 1, "b2b_second");
    step(5);
    if (bits_a !== expect_bits(a) || bits_b !== expect_bits(b)) begin
      errors++; $display("FAIL b2b_bits got=%b/%b exp=%b/%b", bits_a, bits_b, expect_bits(a), expect_bits(b));
    end
    checks++;
    if (done_tot - d0 !== 2 || err_tot - e0 !== 0) begin
      errors++; $display("FAIL b2b_pulses done=%0d err=%0d exp 2/0", done_tot - d0, err_tot - e0);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_frame(8'hED, "ed");
    test_frame(8'hF4, "f4");
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), "rand");
    test_no_clock();
    test_no_ack();
    test_stall();
    test_reset_mid_shift();
    test_valid_while_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Companion to the existing PS/2 receive path. It shares the PS2_CLK/PS2_DAT open-collector lines through output-enable controls.
- tx_busy lets the top level mask the receiver while a host frame is in progress.
- Runs in the CLOCK_50 domain. It generates the inhibit/request-to-send sequence, shifts data on device clock falling edges, and checks the device ACK.

Parameters:
- INHIBIT_CYCLES, 6000, CLOCK_50 cycles PS2_CLK is held low before request-to-send (120 us).
- START_TIMEOUT, 750000, max cycles from clock release to first device falling edge (15 ms).
- FRAME_TIMEOUT, 100000, max cycles from first falling edge to ACK sampled (2 ms).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  send request; accepted when tx_valid && tx_ready.
- tx_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2_CLK line state.
- ps2_dat_in  in  1  raw PS2_DAT line state.
- ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release.
- ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release.
- tx_busy  out  1  high from acceptance until DONE/ERROR exit.
- tx_done  out  1  one-cycle pulse, frame ACKed.
- tx_error  out  1  one-cycle pulse, timeout or missing ACK.

Behaviour:
- Inputs pass through a 2-FF synchronizer. fall_edge = prev_sync_clk & ~sync_clk, which adds 3 cycles of edge latency.
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_error=0, state=IDLE. tx_ready=(state==IDLE) is therefore 1.
- Reset asserted mid-frame releases both lines on the next clock edge with no done/error pulse.
- On acceptance, latch shift = {~^tx_data (odd parity), tx_data}.

States:
- IDLE:
  - Lines released.
  - On accept: go to INHIBIT next cycle; ps2_clk_oe=1 and tx_busy=1 from that cycle.
- INHIBIT:
  - Hold ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - In its final cycle assert ps2_dat_oe=1 (start bit 0).
  - Then go to RTS.
- RTS:
  - ps2_clk_oe=0, ps2_dat_oe=1.
  - Count cycles; START_TIMEOUT reached → ERROR.
  - First fall_edge → SHIFT, bit_cnt=0, drive bit0.
- SHIFT:
  - On each fall_edge drive the next bit: ps2_dat_oe = ~bit, i.e. release the line for 1.
  - Falling edges 1..8 drive data bits 0..7 (LSB first); edge 9 drives parity.
  - Edge 10 releases data (stop bit 1) → ACK.
- ACK:
  - On the next fall_edge (edge 11) sample sync_dat. 0 → WAIT_IDLE; 1 → ERROR.
- WAIT_IDLE:
  - Wait until sync_clk=1 and sync_dat=1, then go to DONE.
  - This wait is covered by FRAME_TIMEOUT → ERROR.
- DONE: tx_done=1 for one cycle, tx_busy=0 → IDLE.
- ERROR: release both lines, tx_error=1 for one cycle, tx_busy=0 → IDLE.

Rules:
- FRAME_TIMEOUT counter starts at the first falling edge. Reaching the limit in SHIFT, ACK or WAIT_IDLE → ERROR.
- tx_valid while not IDLE is ignored; the request is not queued and tx_ready=0.
- Back-to-back: the request may be accepted in the IDLE cycle immediately after DONE/ERROR.
- ps2_dat_oe changes only on a fall_edge cycle (or the RTS entry), never while the device clock is high mid-bit.
- Bit counter is 4 bits; shift register is 9 bits and right-shifts per edge.

Test Plan:
Bench uses INHIBIT_CYCLES=20, START_TIMEOUT=200, FRAME_TIMEOUT=2000, and a device model clocking with a 40-cycle period.
- Send 0xED, device ACKs. Required:
  - ps2_clk_oe high exactly 20 cycles.
  - Sampled bits on rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once; tx_busy 0 afterwards.
- Send 0xF4. Required: parity bit 0, data bits 0,0,1,0,1,1,1,1, tx_done pulse.
- Device never clocks after RTS. Required: tx_error pulses at 200 cycles after clock release; both oe=0; tx_ready=1.
- Device leaves data high on the 11th falling edge (no ACK). Required: tx_error pulse, no tx_done.
- Device stops clocking after the 5th edge. Required: tx_error once FRAME_TIMEOUT is reached; lines released.
- Reset asserted in SHIFT mid-byte, and tx_valid asserted while busy. Required:
  - Reset: both oe=0 the next cycle, state IDLE, no pulses.
  - tx_valid while busy: request ignored, only one frame sent.
